i2c_target_regs: RTL

// I2C target (responder) decoding writes/reads addressed to a 7-bit device address, exposing a

---
 rtl/i2c_pkg.sv | 9 +
 rtl/i2c_target_regs_if.sv | 17 +
 rtl/i2c_bus_monitor.sv | 47 ++++
 rtl/i2c_target_regs.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: target FSM states and well-known addresses/locations
package i2c_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_IGNORE, S_LOC, S_LOC_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK
  } target_state_t;
  localparam logic [6:0] I2C_ADDR_SCROLL_HAT = 7'h74;
  localparam logic [7:0] LOC_COMMAND_REGISTER = 8'hFD;
endpackage

// File: rtl/i2c_target_regs_if.sv
// i2c_target_regs_if: I2C pins plus byte-register strobes between target and its host logic
interface i2c_target_regs_if;
  import i2c_pkg::*;
  logic scl_i, sda_i, scl_o, scl_e, sda_o, sda_e;
  logic wr_strobe, rd_req, addressed, xfer_done;
  logic [7:0] wr_location, wr_data, rd_location, rd_data;
  modport slave (
    input scl_i, sda_i, rd_data,
    output scl_o, scl_e, sda_o, sda_e, wr_strobe, wr_location, wr_data,
    rd_location, rd_req, addressed, xfer_done
  );
  modport master (
    output scl_i, sda_i, rd_data,
    input scl_o, scl_e, sda_o, sda_e, wr_strobe, wr_location, wr_data,
    rd_location, rd_req, addressed, xfer_done
  );
endinterface

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: synchronises and glitch-filters SCL/SDA, emits edge and START/STOP pulses
module i2c_bus_monitor
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic [FILTER_LEN-1:0] scl_hist, sda_hist;
  logic scl_f, sda_f, scl_p, sda_p;
  // Idle bus is high, so everything resets high to avoid a false edge after reset
  always_ff @(posedge clk)
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_hist <= {scl_hist[FILTER_LEN-2:0], scl_sync[SYNC_STAGES-1]};
      sda_hist <= {sda_hist[FILTER_LEN-2:0], sda_sync[SYNC_STAGES-1]};
      scl_f <= &scl_hist ? 1'b1 : ~|scl_hist ? 1'b0 : scl_f;
      sda_f <= &sda_hist ? 1'b1 : ~|sda_hist ? 1'b0 : sda_f;
      scl_p <= scl_f;
      sda_p <= sda_f;
    end
  assign scl_rise = scl_f & ~scl_p;
  assign scl_fall = ~scl_f & scl_p;
  assign start = scl_f & scl_p & sda_p & ~sda_f;
  assign stop = scl_f & scl_p & ~sda_p & sda_f;
  assign sda_s = sda_f;
endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target exposing a byte-register interface with an auto-incrementing location pointer
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS = I2C_ADDR_SCROLL_HAT,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN = 3
) (
  input logic clk,
  input logic reset_n,
  i2c_target_regs_if.slave bus
);
  target_state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] shift, shift_n, ptr, ptr_n, wl, wl_n, wd, wd_n, byte_in;
  logic sda_e, sda_e_n, addr, addr_n, rw, rw_n, mack, mack_n;
  logic wr, wr_n, xd, xd_n, rd_req, ld;
  logic scl_rise, scl_fall, start, stop, sda_s;
  i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_mon (
    .clk(clk), .reset_n(reset_n), .scl_i(bus.scl_i), .sda_i(bus.sda_i),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop), .sda_s(sda_s)
  );
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= S_IDLE;
      cnt <= '0;
      shift <= '0;
      ptr <= '0;
      wl <= '0;
      wd <= '0;
      sda_e <= 1'b0;
      addr <= 1'b0;
      rw <= 1'b0;
      mack <= 1'b0;
      wr <= 1'b0;
      xd <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      shift <= shift_n;
      ptr <= ptr_n;
      wl <= wl_n;
      wd <= wd_n;
      sda_e <= sda_e_n;
      addr <= addr_n;
      rw <= rw_n;
      mack <= mack_n;
      wr <= wr_n;
      xd <= xd_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    shift_n = shift;
    ptr_n = ptr;
    wl_n = wl;
    wd_n = wd;
    sda_e_n = sda_e;
    addr_n = addr;
    rw_n = rw;
    mack_n = mack;
    wr_n = 1'b0;
    xd_n = 1'b0;
    rd_req = 1'b0;
    ld = 1'b0;
    byte_in = {shift[6:0], sda_s};
    if (stop) begin
      state_n = S_IDLE;
      sda_e_n = 1'b0;
      addr_n = 1'b0;
      xd_n = addr;
    end else if (start) begin
      state_n = S_ADDR;
      cnt_n = '0;
      sda_e_n = 1'b0;
      addr_n = 1'b0;
    end else if (scl_rise) begin
      cnt_n = cnt + 3'd1;
      shift_n = state inside {S_ADDR, S_LOC, S_WDATA} ? byte_in : shift;
      case (state)
        S_ADDR: if (cnt == 3'd7) begin
          state_n = byte_in[7:1] == ADDRESS ? S_ADDR_ACK : S_IGNORE;
          rw_n = sda_s;
        end
        S_LOC: if (cnt == 3'd7) begin
          state_n = S_LOC_ACK;
          ptr_n = byte_in;
        end
        S_WDATA: if (cnt == 3'd7) begin
          state_n = S_WDATA_ACK;
          wr_n = 1'b1;
          wl_n = ptr;
          wd_n = byte_in;
          ptr_n = ptr + 8'd1;
        end
        S_RDATA: state_n = cnt == 3'd7 ? S_RACK : S_RDATA;
        S_RACK: begin
          state_n = sda_s ? S_IGNORE : S_RACK;
          mack_n = ~sda_s;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state)
        // sda_e low marks the 8th fall (start of ACK slot), high marks the 9th (end of it)
        S_ADDR_ACK, S_LOC_ACK, S_WDATA_ACK:
          if (!sda_e) begin
            sda_e_n = 1'b1;
            addr_n = addr | (state == S_ADDR_ACK);
          end else if (state == S_ADDR_ACK && rw) ld = 1'b1;
          else begin
            sda_e_n = 1'b0;
            cnt_n = '0;
            state_n = state == S_ADDR_ACK ? S_LOC : S_WDATA;
          end
        S_RDATA: begin
          shift_n = {shift[6:0], 1'b0};
          sda_e_n = ~shift[6];
        end
        S_RACK: if (mack) ld = 1'b1;
          else sda_e_n = 1'b0;
        default: ;
      endcase
    end
    if (ld) begin
      rd_req = 1'b1;
      shift_n = bus.rd_data;
      sda_e_n = ~bus.rd_data[7];
      ptr_n = ptr + 8'd1;
      cnt_n = '0;
      mack_n = 1'b0;
      state_n = S_RDATA;
    end
  end
  assign bus.scl_o = 1'b0;
  assign bus.scl_e = 1'b0;
  assign bus.sda_o = 1'b0;
  assign bus.sda_e = sda_e;
  assign bus.wr_strobe = wr;
  assign bus.wr_location = wl;
  assign bus.wr_data = wd;
  assign bus.rd_location = ptr;
  assign bus.rd_req = rd_req;
  assign bus.addressed = addr;
  assign bus.xfer_done = xd;
endmodule
